// File: rtl/flit_tx_port.sv
`default_nettype none
// ============================================================================
//  Module   : flit_tx_port
//  Purpose  : Credit-based flit transmitter feeding one router input port.
//             Flits from a local source are buffered in a small FIFO and
//             sent downstream one per cycle only while a downstream buffer
//             credit is held. Each credit_in pulse returns one credit.
//  Ports    :
//    clk          - system clock, rising edge
//    rst          - synchronous reset, active high
//    src_valid    - source flit valid
//    src_flit     - source flit data [FW]
//    src_ready    - FIFO can accept a flit this cycle
//    tx_en        - transmit enable (0 holds flits in the FIFO)
//    flit_out_wr  - one-cycle write strobe to downstream input queue
//    flit_out     - flit data, valid while flit_out_wr=1 [FW]
//    credit_in    - one-cycle credit return pulse from downstream
//    credit_cnt   - available downstream credits [clog2(B+1)]
//    fifo_cnt     - flits currently buffered [clog2(QD+1)]
//    credit_err   - sticky credit-overflow error
//    idle         - FIFO empty and all credits home
//  Revision : 1.0 - initial release
// ============================================================================
module flit_tx_port #(
    parameter int FW = 64,
    parameter int B  = 4,
    parameter int QD = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     src_valid,
    input  logic [FW-1:0]            src_flit,
    output logic                     src_ready,
    input  logic                     tx_en,
    output logic                     flit_out_wr,
    output logic [FW-1:0]            flit_out,
    input  logic                     credit_in,
    output logic [$clog2(B+1)-1:0]   credit_cnt,
    output logic [$clog2(QD+1)-1:0]  fifo_cnt,
    output logic                     credit_err,
    output logic                     idle
);

    localparam int CW  = $clog2(B + 1);
    localparam int QCW = $clog2(QD + 1);
    localparam int PW  = $clog2(QD);

    localparam logic [CW-1:0]  CRED_FULL = CW'(B);
    localparam logic [QCW-1:0] FIFO_FULL = QCW'(QD);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [FW-1:0]  mem_q [QD];
    logic [FW-1:0]  mem_d [QD];
    logic [PW-1:0]  wr_ptr_q,      wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q,      rd_ptr_d;
    logic [QCW-1:0] fifo_cnt_q,    fifo_cnt_d;
    logic [CW-1:0]  credit_cnt_q,  credit_cnt_d;
    logic [FW-1:0]  flit_out_q,    flit_out_d;
    logic           flit_out_wr_q, flit_out_wr_d;
    logic           credit_err_q,  credit_err_d;

    logic           w_push;
    logic           w_send;

    // ------------------------------------------------------------------
    // Handshake decode: purely from registered state, so a pop in the
    // same cycle does not open a slot for the source.
    // ------------------------------------------------------------------
    assign src_ready = (fifo_cnt_q < FIFO_FULL);
    assign w_push    = src_valid && src_ready;
    assign w_send    = tx_en && (fifo_cnt_q != '0) && (credit_cnt_q != '0);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        fifo_cnt_d    = fifo_cnt_q;
        credit_cnt_d  = credit_cnt_q;
        flit_out_d    = flit_out_q;
        flit_out_wr_d = 1'b0;
        credit_err_d  = credit_err_q;

        if (w_push) begin
            mem_d[wr_ptr_q] = src_flit;
            // QD is a power of two, so natural pointer overflow wraps.
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end

        if (w_send) begin
            flit_out_d    = mem_q[rd_ptr_q];
            flit_out_wr_d = 1'b1;
            rd_ptr_d      = rd_ptr_q + PW'(1);
        end

        case ({w_push, w_send})
            2'b10:   fifo_cnt_d = fifo_cnt_q + QCW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - QCW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        case ({w_send, credit_in})
            2'b10: credit_cnt_d = credit_cnt_q - CW'(1);
            2'b01: begin
                // A returned credit with every credit already home means
                // downstream and this port disagree; saturate and flag.
                if (credit_cnt_q == CRED_FULL) begin
                    credit_err_d = 1'b1;
                end else begin
                    credit_cnt_d = credit_cnt_q + CW'(1);
                end
            end
            default: credit_cnt_d = credit_cnt_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
            credit_cnt_q  <= CRED_FULL;
            flit_out_q    <= '0;
            flit_out_wr_q <= 1'b0;
            credit_err_q  <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            credit_cnt_q  <= credit_cnt_d;
            flit_out_q    <= flit_out_d;
            flit_out_wr_q <= flit_out_wr_d;
            credit_err_q  <= credit_err_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign flit_out_wr = flit_out_wr_q;
    assign flit_out    = flit_out_q;
    assign credit_cnt  = credit_cnt_q;
    assign fifo_cnt    = fifo_cnt_q;
    assign credit_err  = credit_err_q;
    assign idle        = (fifo_cnt_q == '0) && (credit_cnt_q == CRED_FULL);

endmodule
`default_nettype wire

// File: tb/tb_flit_tx_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flit_tx_port
//  Purpose  : Self-checking bench for flit_tx_port. A queue/counter model
//             tracks buffered flits, credits and the error flag; every
//             cycle all DUT outputs are compared with it. Directed
//             scenarios are followed by a randomized phase.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_flit_tx_port;

    localparam int FW  = 64;
    localparam int B   = 4;
    localparam int QD  = 4;
    localparam int CW  = $clog2(B + 1);
    localparam int QCW = $clog2(QD + 1);

    logic           clk;
    logic           rst;
    logic           src_valid;
    logic [FW-1:0]  src_flit;
    logic           src_ready;
    logic           tx_en;
    logic           flit_out_wr;
    logic [FW-1:0]  flit_out;
    logic           credit_in;
    logic [CW-1:0]  credit_cnt;
    logic [QCW-1:0] fifo_cnt;
    logic           credit_err;
    logic           idle;

    flit_tx_port #(
        .FW (FW),
        .B  (B),
        .QD (QD)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .src_valid   (src_valid),
        .src_flit    (src_flit),
        .src_ready   (src_ready),
        .tx_en       (tx_en),
        .flit_out_wr (flit_out_wr),
        .flit_out    (flit_out),
        .credit_in   (credit_in),
        .credit_cnt  (credit_cnt),
        .fifo_cnt    (fifo_cnt),
        .credit_err  (credit_err),
        .idle        (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [FW-1:0] m_q [$];
    int            m_cred;
    logic          m_err;
    logic [FW-1:0] m_out;
    logic          m_wr;
    logic          m_push;

    int n_checks;
    int n_fail;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Applies the rules for one clock edge using the inputs as they stand.
    task automatic model_edge();
        logic ready;
        logic send;
        if (rst) begin
            m_q.delete();
            m_cred = B;
            m_err  = 1'b0;
            m_out  = '0;
            m_wr   = 1'b0;
            m_push = 1'b0;
        end else begin
            ready  = (m_q.size() < QD);
            m_push = src_valid && ready;
            send   = tx_en && (m_q.size() > 0) && (m_cred > 0);
            m_wr   = send;
            if (send) m_out = m_q.pop_front();
            if (m_push) m_q.push_back(src_flit);
            if (send && !credit_in) begin
                m_cred = m_cred - 1;
            end else if (credit_in && !send) begin
                if (m_cred == B) m_err = 1'b1;
                else             m_cred = m_cred + 1;
            end
        end
    endtask

    task automatic check_all();
        check_eq("src_ready",   64'(src_ready),   64'(m_q.size() < QD));
        check_eq("fifo_cnt",    64'(fifo_cnt),    64'(m_q.size()));
        check_eq("credit_cnt",  64'(credit_cnt),  64'(m_cred));
        check_eq("idle",        64'(idle),        64'((m_q.size() == 0) && (m_cred == B)));
        check_eq("flit_out_wr", 64'(flit_out_wr), 64'(m_wr));
        check_eq("flit_out",    64'(flit_out),    64'(m_out));
        check_eq("credit_err",  64'(credit_err),  64'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic push_flit(input logic [FW-1:0] f, input int max_cycles);
        logic done;
        done      = 1'b0;
        src_valid = 1'b1;
        src_flit  = f;
        for (int i = 0; i < max_cycles && !done; i++) begin
            tick();
            if (m_push) done = 1'b1;
        end
        src_valid = 1'b0;
        if (!done) check_eq("push_timeout", 64'(done), 64'(1));
    endtask

    // Downstream that frees a slot every cycle it is owed one.
    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (m_q.size() == 0 && m_cred == B) break;
            credit_in = (m_cred < B);
            tick();
        end
        credit_in = 1'b0;
        check_eq("drain_idle", 64'(idle), 64'(1));
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        src_valid = 1'b0;
        src_flit  = '0;
        tx_en     = 1'b0;
        credit_in = 1'b0;
        m_cred    = B;
        m_err     = 1'b0;
        m_out     = '0;
        m_wr      = 1'b0;
        m_push    = 1'b0;

        // Reset and idle
        tick();
        rst = 1'b0;
        tick();
        tick();
        check_eq("rst_credit", 64'(credit_cnt), 64'(4));
        check_eq("rst_fifo",   64'(fifo_cnt),   64'(0));
        check_eq("rst_ready",  64'(src_ready),  64'(1));
        check_eq("rst_idle",   64'(idle),       64'(1));
        check_eq("rst_wr",     64'(flit_out_wr), 64'(0));
        check_eq("rst_err",    64'(credit_err), 64'(0));

        // Single flit latency
        tx_en = 1'b1;
        push_flit(64'hA5, 1);
        check_eq("single_no_early_wr", 64'(flit_out_wr), 64'(0));
        tick();
        check_eq("single_wr",     64'(flit_out_wr), 64'(1));
        check_eq("single_data",   flit_out,         64'hA5);
        check_eq("single_credit", 64'(credit_cnt),  64'(3));
        tick();
        check_eq("single_wr_drop", 64'(flit_out_wr), 64'(0));
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        check_eq("single_credit_back", 64'(credit_cnt), 64'(4));
        check_eq("single_idle",        64'(idle),       64'(1));

        // Credit exhaustion with six flits
        for (int i = 1; i <= 6; i++) push_flit(64'(i), 4);
        tick();
        tick();
        check_eq("exhaust_credit", 64'(credit_cnt), 64'(0));
        check_eq("exhaust_fifo",   64'(fifo_cnt),   64'(2));
        for (int i = 5; i <= 6; i++) begin
            credit_in = 1'b1;
            tick();
            credit_in = 1'b0;
            tick();
            check_eq("release_wr",   64'(flit_out_wr), 64'(1));
            check_eq("release_data", flit_out,         64'(i));
        end
        drain(20);

        // Simultaneous send and credit return at credit_cnt=2
        tx_en = 1'b0;
        for (int i = 0; i < 3; i++) push_flit(64'h100 + 64'(i), 2);
        tx_en = 1'b1;
        tick();
        tick();
        check_eq("pre_both_credit", 64'(credit_cnt), 64'(2));
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        check_eq("both_credit", 64'(credit_cnt), 64'(2));
        check_eq("both_wr",     64'(flit_out_wr), 64'(1));
        check_eq("both_data",   flit_out,         64'h102);
        drain(20);

        // Backpressure with tx_en=0
        tx_en = 1'b0;
        for (int i = 0; i < 4; i++) push_flit(64'h200 + 64'(i), 2);
        src_valid = 1'b1;
        src_flit  = 64'h204;
        tick();
        tick();
        check_eq("full_ready", 64'(src_ready), 64'(0));
        check_eq("full_fifo",  64'(fifo_cnt),  64'(4));
        tx_en = 1'b1;
        push_flit(64'h204, 5);
        drain(30);

        // Credit overflow then mid-operation reset
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        check_eq("ovf_err",    64'(credit_err), 64'(1));
        check_eq("ovf_credit", 64'(credit_cnt), 64'(4));
        tx_en = 1'b0;
        for (int i = 0; i < 3; i++) push_flit(64'h300 + 64'(i), 2);
        tick();
        check_eq("err_sticky", 64'(credit_err), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rst_fifo",   64'(fifo_cnt),    64'(0));
        check_eq("mid_rst_credit", 64'(credit_cnt),  64'(4));
        check_eq("mid_rst_err",    64'(credit_err),  64'(0));
        check_eq("mid_rst_wr",     64'(flit_out_wr), 64'(0));
        tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            tx_en = ($urandom_range(0, 3) != 0);
            if (!(src_valid && !m_push)) begin
                src_valid = ($urandom_range(0, 1) == 1);
                src_flit  = {$urandom, $urandom};
            end
            credit_in = (m_cred < B) && ($urandom_range(0, 2) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst       = 1'b0;
        src_valid = 1'b0;
        tx_en     = 1'b1;
        drain(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/flit_tx_port.md
Name: flit_tx_port

Overview:
Credit-based flit transmitter that drives one router input port (the flit_in_wr / flit_in / credit_out side of an input queue). It buffers flits from a local source, such as a neuron core injection path or a router output stage, in a small FIFO. It sends a flit only when it holds a downstream buffer credit, and it reclaims one credit per credit pulse returned by the receiving input queue.

Parameters:
FW, 64, flit width in bits
B, 4, downstream input-queue depth in flits; this is the credit count loaded at reset
QD, 4, local transmit FIFO depth in flits (power of two, at least 2)

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous reset, active-high
src_valid  input  1  source flit valid
src_flit  input  FW  source flit data
src_ready  output  1  FIFO can accept a flit this cycle
tx_en  input  1  transmit enable; 0 holds flits in the FIFO
flit_out_wr  output  1  one-cycle write strobe to the downstream input queue
flit_out  output  FW  flit data, valid when flit_out_wr=1
credit_in  input  1  one-cycle credit return pulse from downstream (one freed slot)
credit_cnt  output  clog2(B+1)  current available downstream credits
fifo_cnt  output  clog2(QD+1)  flits currently buffered
credit_err  output  1  sticky credit-overflow error
idle  output  1  FIFO empty and credit_cnt==B

Behaviour:
- Reset (rst=1 at a clk edge) sets outputs and state as follows:
  - credit_cnt=B, fifo_cnt=0, FIFO pointers=0
  - flit_out_wr=0, flit_out=0, credit_err=0
  - src_ready=1 and idle=1 in the cycle after reset
  - Reset mid-operation discards all buffered flits and restores full credits. In-flight downstream state is not tracked.
- Accept: src_ready = (fifo_cnt<QD), computed combinationally from registered state with no same-cycle pop bypass. A push happens when src_valid and src_ready are both 1 at an edge. src_valid with src_ready=0 is ignored; the source must hold the flit.
- Send condition at an edge: send = tx_en & (fifo_cnt>0) & (credit_cnt>0).
  - On send, the FIFO head is popped into the flit_out register and flit_out_wr=1 for the following cycle.
  - Otherwise flit_out_wr=0 and flit_out holds its last value.
- At most one flit is sent per cycle, so back-to-back sends give a continuous flit_out_wr.
- Latency: a flit pushed at edge t is earliest sent at edge t+1, i.e. flit_out_wr is high in the cycle after edge t+1. There is no bypass from src_flit to flit_out.
- Ordering: strict FIFO, with no reordering or duplication.
- FIFO count: push without pop gives +1, pop without push gives -1, and push with pop leaves it unchanged. Push on a full FIFO and pop on an empty FIFO are impossible by construction.
- Credit count update:
  - send without credit_in: -1
  - credit_in without send: +1
  - both together: unchanged
  - credit_cnt never goes below 0 because send requires credit_cnt>0.
- Credit overflow: if credit_in=1 with no send while credit_cnt==B, then credit_cnt stays at B and credit_err is set to 1. credit_err stays 1 until rst.
- Pointer wrap: read and write pointers are modulo QD, and full/empty are decided by fifo_cnt.
- tx_en=0 blocks sends only. Pushes and credit returns continue.
- idle is a registered-state decode with no extra latency.

Test Plan:
- Reset, then idle with no stimulus: credit_cnt=4, fifo_cnt=0, src_ready=1, idle=1, flit_out_wr=0, credit_err=0.
- Single flit 0xA5 pushed at edge t with tx_en=1: flit_out_wr=1 with flit_out=0xA5 in the cycle after edge t+1 only, then credit_cnt=3. A credit_in pulse afterwards returns credit_cnt to 4 and idle to 1.
- Push flits 1..6 back-to-back with no credit_in:
  - flits 1-4 are sent on consecutive cycles and credit_cnt reaches 0;
  - flits 5 and 6 stay buffered with fifo_cnt=2;
  - two credit_in pulses release 5 then 6 in order.
- With credit_cnt=2 and FIFO non-empty, assert credit_in in the same cycle as a send: credit_cnt stays 2 and flit_out_wr=1.
- tx_en=0 while pushing 5 flits: fifo_cnt saturates at 4 and src_ready=0, so the 5th flit is held by the source with no loss. Setting tx_en=1 drains in order and the 5th flit is accepted once src_ready=1.
- Overflow and mid-operation reset:
  - credit_in pulse at credit_cnt=4 with no send: credit_err=1 and credit_cnt=4.
  - rst asserted with 3 buffered flits: next cycle fifo_cnt=0, credit_cnt=4, credit_err=0, and no flit_out_wr.
